// File: rtl/microseq_if.sv
// Handshake and microcode-load bundle for the microprogram sequencer.
// The master side starts runs and loads code; the slave side is the sequencer.
interface microseq_if #(
  parameter int ADDR_W = 4,
  parameter int N_COND = 2,
  parameter int OUT_W  = 4
);
  localparam int CSEL_W =
    (N_COND > 1) ? $clog2(N_COND) : 1;
  localparam int MI_W =
    3 + CSEL_W + 1 + ADDR_W + OUT_W;

  logic              start;
  logic [N_COND-1:0] cond;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [MI_W-1:0]   prog_data;
  logic [OUT_W-1:0]  out;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, cond,
    output prog_we, prog_addr, prog_data,
    input  out, pc, busy, done, err
  );

  modport slave (
    input  start, cond,
    input  prog_we, prog_addr, prog_data,
    output out, pc, busy, done, err
  );
endinterface

// File: rtl/microseq.sv
// Microprogram sequencer: loadable store, cond branches/waits,
// start/busy/done handshake and a step watchdog.
module microseq #(
  parameter int ADDR_W     = 4,
  parameter int N_COND     = 2,
  parameter int OUT_W      = 4,
  parameter int START_ADDR = 0,
  parameter int MAX_STEPS  = 64
) (
  input logic       clk,
  input logic       reset,
  microseq_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CSEL_W =
    (N_COND > 1) ? $clog2(N_COND) : 1;
  localparam int MI_W =
    3 + CSEL_W + 1 + ADDR_W + OUT_W;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_WAIT = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  localparam logic [ADDR_W-1:0] PC0 =
    ADDR_W'(START_ADDR);
  localparam logic [15:0] LAST_STEP =
    16'(MAX_STEPS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            st, st_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [OUT_W-1:0]  out_q, out_n;
  logic [15:0]       steps, steps_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  logic [MI_W-1:0]   mem [DEPTH];
  logic [MI_W-1:0]   mi;
  logic [2:0]        op;
  logic [CSEL_W-1:0] csel;
  logic              pol;
  logic [ADDR_W-1:0] target;
  logic [OUT_W-1:0]  outv;
  logic [ADDR_W-1:0] pc_inc;
  logic              c;
  logic              busy;

  assign busy   = (st == RUN);
  assign mi     = mem[pc_q];
  assign op     = mi[MI_W-1 -: 3];
  assign csel   = mi[ADDR_W+OUT_W+1 +: CSEL_W];
  assign pol    = mi[ADDR_W+OUT_W];
  assign target = mi[OUT_W +: ADDR_W];
  assign outv   = mi[OUT_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  // Out-of-range selects evaluate false.
  always_comb begin
    c = 1'b0;
    for (int i = 0; i < N_COND; i++) begin
      if (csel == CSEL_W'(i))
        c = (bus.cond[i] == pol);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st     <= IDLE;
      pc_q   <= PC0;
      out_q  <= '0;
      steps  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      st     <= st_n;
      pc_q   <= pc_n;
      out_q  <= out_n;
      steps  <= steps_n;
      done_q <= done_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    st_n    = st;
    pc_n    = pc_q;
    out_n   = out_q;
    steps_n = steps;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.start) begin
          st_n    = RUN;
          pc_n    = PC0;
          steps_n = '0;
        end
      end
      RUN: begin
        steps_n = steps + 16'd1;
        if (op >= OP_HALT) begin
          st_n   = IDLE;
          pc_n   = PC0;
          out_n  = outv;
          done_n = (op == OP_HALT);
          err_n  = (op != OP_HALT);
        end else if (steps == LAST_STEP) begin
          // Watchdog abort leaves out untouched.
          st_n  = IDLE;
          pc_n  = PC0;
          err_n = 1'b1;
        end else begin
          out_n = outv;
          unique case (1'b1)
            (op == OP_NEXT): pc_n = pc_inc;
            (op == OP_JUMP): pc_n = target;
            (op == OP_BR):   pc_n = c ? target : pc_inc;
            (op == OP_WAIT): pc_n = c ? pc_inc : pc_q;
            default:         pc_n = pc_inc;
          endcase
        end
      end
      default: st_n = IDLE;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.pc   = pc_q;
  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_microseq.sv
// Directed bench for microseq: linear, branch, wait, watchdog,
// illegal opcode, wrap, store protection and mid-run reset.
module tb_microseq;
  localparam int ADDR_W = 4;
  localparam int N_COND = 2;
  localparam int OUT_W  = 4;
  localparam int MAXS   = 64;
  localparam int MI_W   = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  microseq_if #(
    .ADDR_W(ADDR_W),
    .N_COND(N_COND),
    .OUT_W (OUT_W)
  ) bus ();

  microseq #(
    .ADDR_W    (ADDR_W),
    .N_COND    (N_COND),
    .OUT_W     (OUT_W),
    .START_ADDR(0),
    .MAX_STEPS (MAXS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [MI_W-1:0] mi(
    input logic [2:0] op,
    input logic       cs,
    input logic       pol,
    input logic [3:0] tgt,
    input logic [3:0] ov
  );
    return {op, cs, pol, tgt, ov};
  endfunction

  task automatic load(int a, logic [MI_W-1:0] d);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = ADDR_W'(a);
    bus.prog_data = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic go();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic st(string t, int o, int p, int b, int d, int e);
    check({t, ".out"}, int'(bus.out), o);
    check({t, ".pc"}, int'(bus.pc), p);
    check({t, ".busy"}, int'(bus.busy), b);
    check({t, ".done"}, int'(bus.done), d);
    check({t, ".err"}, int'(bus.err), e);
  endtask

  initial begin
    int n;
    bit sd;
    bus.start     = 1'b0;
    bus.cond      = '0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    repeat (2) step();
    reset = 1'b0;
    st("rst", 0, 0, 0, 0, 0);

    // linear run; start held one extra cycle while busy
    load(0, mi(3'd0, 1'b0, 1'b0, 4'd0, 4'd1));
    load(1, mi(3'd0, 1'b0, 1'b0, 4'd0, 4'd2));
    load(2, mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd3));
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    st("lin0", 0, 0, 1, 0, 0);
    @(negedge clk);
    bus.start = 1'b0;
    st("lin1", 1, 1, 1, 0, 0);
    step();
    st("lin2", 2, 2, 1, 0, 0);
    step();
    st("lin3", 3, 0, 0, 1, 0);
    step();
    st("lin4", 3, 0, 0, 0, 0);

    // branch taken / not taken
    load(0, mi(3'd2, 1'b0, 1'b1, 4'd4, 4'd1));
    load(1, mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd2));
    load(4, mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd5));
    bus.cond = 2'b01;
    go();
    step();
    st("brT1", 1, 4, 1, 0, 0);
    step();
    st("brT2", 5, 0, 0, 1, 0);
    bus.cond = 2'b00;
    go();
    step();
    st("brN1", 1, 1, 1, 0, 0);
    step();
    st("brN2", 2, 0, 0, 1, 0);

    // wait loop; write attempt during the run must be dropped
    load(0, mi(3'd3, 1'b1, 1'b1, 4'd0, 4'd6));
    load(1, mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd7));
    bus.cond = 2'b00;
    go();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd1;
    bus.prog_data = mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd14);
    for (int i = 0; i < 5; i++) begin
      step();
      st("wait", 6, 0, 1, 0, 0);
    end
    bus.prog_we = 1'b0;
    bus.cond = 2'b10;
    step();
    st("wrel", 6, 1, 1, 0, 0);
    step();
    st("wend", 7, 0, 0, 1, 0);

    // reset mid-run, then rerun same program
    bus.cond = 2'b00;
    go();
    step();
    st("mr0", 6, 0, 1, 0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    st("mrrst", 0, 0, 0, 0, 0);
    go();
    step();
    st("rr1", 6, 0, 1, 0, 0);
    bus.cond = 2'b10;
    step();
    st("rr2", 6, 1, 1, 0, 0);
    step();
    st("rr3", 7, 0, 0, 1, 0);

    // illegal opcode
    load(0, mi(3'd6, 1'b0, 1'b0, 4'd3, 4'd10));
    go();
    step();
    st("ill1", 10, 0, 0, 0, 1);
    step();
    st("ill2", 10, 0, 0, 0, 0);

    // watchdog on a self-loop
    load(0, mi(3'd1, 1'b0, 1'b0, 4'd0, 4'd9));
    go();
    n = 0;
    sd = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (bus.done) sd = 1'b1;
      if (bus.err) begin
        n = i;
        break;
      end
    end
    check("wd.cycles", n, MAXS);
    check("wd.nodone", int'(sd), 0);
    st("wd", 9, 0, 0, 0, 1);
    step();
    check("wd.errclr", int'(bus.err), 0);

    // pc wrap DEPTH-1 -> 0
    load(0, mi(3'd2, 1'b0, 1'b1, 4'd15, 4'd1));
    load(1, mi(3'd4, 1'b0, 1'b0, 4'd0, 4'd13));
    load(15, mi(3'd0, 1'b0, 1'b0, 4'd0, 4'd12));
    bus.cond = 2'b01;
    go();
    step();
    st("wr1", 1, 15, 1, 0, 0);
    bus.cond = 2'b00;
    step();
    st("wr2", 12, 0, 1, 0, 0);
    step();
    st("wr3", 1, 1, 1, 0, 0);
    step();
    st("wr4", 13, 0, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/microseq.md
# microseq

Parametrised microprogram sequencer. It executes a loadable microcode store of DEPTH words and drives an OUT_W-bit control word from each executed microinstruction. Branches and waits are taken on N_COND condition inputs. It is the generic replacement for the hard-coded state-sequence controllers in the lab designs: flows are written to the store rather than coded as FSM case arms, and the block adds start/busy/done handshaking and a runaway watchdog.

## Interface
Parameters:
- ADDR_W, 4: microcode address width; DEPTH = 2**ADDR_W.
- N_COND, 2: number of condition inputs.
- OUT_W, 4: control-word width.
- START_ADDR, 0: entry address on start.
- MAX_STEPS, 64: watchdog limit on executed instructions per run (1..65535).
- Derived CSEL_W = max(1, clog2(N_COND)); MI_W = 3 + CSEL_W + 1 + ADDR_W + OUT_W.

Ports (one clock; reset is synchronous and active-high):
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous active-high reset.
- start, in, 1: begin a run; sampled only in IDLE.
- cond, in, N_COND: condition inputs, sampled at the execute edge.
- prog_we, in, 1: microcode write enable.
- prog_addr, in, ADDR_W: write address.
- prog_data, in, MI_W: microinstruction to write.
- out, out, OUT_W: registered control word.
- pc, out, ADDR_W: current microprogram address.
- busy, out, 1: high while running.
- done, out, 1: one-cycle pulse on normal HALT.
- err, out, 1: one-cycle pulse on illegal opcode or watchdog abort.

## Operation
- Microinstruction fields, MSB to LSB: op[2:0] | csel[CSEL_W] | pol | target[ADDR_W] | outv[OUT_W].
- Condition: c = (csel < N_COND) ? (cond[csel] == pol) : 0.
- Opcodes:
  - 0 NEXT: pc <= pc+1.
  - 1 JUMP: pc <= target.
  - 2 BRANCH: pc <= c ? target : pc+1.
  - 3 WAIT: pc <= c ? pc+1 : pc.
  - 4 HALT: end the run.
  - 5–7 illegal: handled like HALT but pulse err instead of done.
- Every executed instruction, HALT included, loads out <= outv.
- pc+1 wraps modulo DEPTH (DEPTH-1 → 0).
- States:
  - IDLE: busy=0. start=1 → RUN; pc <= START_ADDR; step counter <= 0.
  - RUN: busy=1. Execute mem[pc] each edge and increment the step counter.
  - On HALT or illegal opcode: → IDLE; pc <= START_ADDR.
  - If the step counter reaches MAX_STEPS without a HALT: abort → IDLE, err=1, out keeps the last value.
- Microcode store: DEPTH×MI_W register array, asynchronous read by pc.
  - Writes are accepted only while busy=0; prog_we is ignored while busy=1.
  - Contents are not cleared by reset.
- start while busy=1 is ignored. A start on the same edge that returns to IDLE is also ignored; a new run needs start in a later IDLE cycle.

## Timing
- Reset (synchronous): out=0, pc=START_ADDR, busy=0, done=0, err=0, state IDLE, step counter 0.
- Start latency: start=1 at edge k → busy=1 and pc=START_ADDR after edge k. The first instruction executes at edge k+1.
- One instruction per cycle. out reflects the instruction executed at the previous edge.
- HALT executed at edge n: after edge n, out=outv, done=1, busy=0. done clears after edge n+1.
- Watchdog: a run that never halts aborts at edge k+MAX_STEPS, with err=1 and busy=0 after that edge.
- prog_we together with start in IDLE: the write lands at edge k and is visible to the first execute at edge k+1.
- Reset mid-run: abort at the next edge with reset values; no done or err pulse; the store is preserved.
- cond must be stable around the execute edge. There is no internal synchronisation.

## Test plan
- Linear run: load NEXT(out=1), NEXT(out=2), HALT(out=3) at 0..2; pulse start → out = 1, 2, 3 on consecutive cycles; done pulses with out=3; busy high for exactly 3 cycles.
- Branch: load 0: BRANCH csel=0 pol=1 target=4 out=1; 1: HALT out=2; 4: HALT out=5.
  - cond=2'b01 → out sequence 1, 5.
  - cond=2'b00 → out sequence 1, 2.
- Wait loop: 0: WAIT csel=1 pol=1 out=6; 1: HALT out=7. Hold cond[1]=0 for 5 cycles then raise it → pc stays 0 and out stays 6 for 5 cycles, then out=7 and done.
- Watchdog and illegal opcode:
  - 0: JUMP target=0 with MAX_STEPS=64 → err pulse exactly 64 cycles after the first execute; busy=0; no done.
  - Separately, opcode 6 at address 0 → err pulse after 1 cycle; out=outv.
- Wrap and protection:
  - NEXT at DEPTH-1 → pc=0 next.
  - prog_we during a run leaves the store unchanged (verified by a later run).
  - start while busy is ignored.
- Reset mid-run: assert reset during a WAIT → next cycle out=0, busy=0, pc=START_ADDR; a rerun with unchanged program reproduces the original output sequence.
